instruction_fetch_stage: RTL
============================

Name: instruction_fetch_stage

Overview:
- IF stage of the RISC-V pipeline.
- Owns the PC register and next-PC selection.
- Drives the fetch address to the asynchronous program ROM, which returns the instruction combinationally in the same cycle.
- Captures PC, PC+4 and the instruction into the IF/ID pipeline register, under stall and flush control from the hazard unit and the EX-stage branch resolver.

Parameters:
- DATA_WIDTH, 32, width of PC, address, and instruction.
- RESET_PC, 32'h0040_0000, PC value loaded on reset; text-segment base.
- NOP_INSTR, 32'h0000_0013, instruction written into IF/ID on flush or reset (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall_i  input  1  hazard unit: hold PC and IF/ID (load-use).
- redirect_i  input  1  EX stage: taken branch or jump; flush IF/ID and load the new target.
- redirect_target_i  input  DATA_WIDTH  target PC for redirect.
- instruction_i  input  DATA_WIDTH  instruction from the program ROM for the current fetch_address_o.
- fetch_address_o  output  DATA_WIDTH  current PC to the program ROM (combinational copy of the PC register).
- if_id_pc_o  output  DATA_WIDTH  PC of the instruction held in IF/ID.
- if_id_pc_plus4_o  output  DATA_WIDTH  if_id_pc_o + 4.
- if_id_instruction_o  output  DATA_WIDTH  instruction held in IF/ID.
- if_id_valid_o  output  1  IF/ID holds a real instruction (0 means bubble).
- misaligned_o  output  1  one-cycle pulse: redirect target had [1:0] != 0.
- fetch_count_o  output  DATA_WIDTH  count of instructions accepted into IF/ID; saturates at all-ones.

Behaviour:
- Reset (sync, highest priority):
  - PC = RESET_PC.
  - if_id_pc_o = 0, if_id_pc_plus4_o = 0.
  - if_id_instruction_o = NOP_INSTR, if_id_valid_o = 0.
  - misaligned_o = 0, fetch_count_o = 0.
- fetch_address_o = PC; no register between the PC and the ROM.
- pc_plus4 = PC + 4, modulo 2^DATA_WIDTH; wraps 0xFFFF_FFFC to 0 silently.
- Priority on each rising edge when not in reset: redirect_i > stall_i > normal.
- Normal (redirect=0, stall=0):
  - PC <= pc_plus4.
  - IF/ID <= {PC, pc_plus4, instruction_i}, valid <= 1.
  - fetch_count++.
- Stall (redirect=0, stall=1):
  - PC, IF/ID, valid and fetch_count all hold.
  - ROM output is ignored that cycle.
- Redirect (redirect=1, regardless of stall):
  - PC <= {redirect_target_i[DATA_WIDTH-1:2], 2'b00}.
  - IF/ID instruction <= NOP_INSTR, valid <= 0; IF/ID PC fields <= 0.
  - fetch_count holds.
  - misaligned_o <= |redirect_target_i[1:0] for exactly one cycle; otherwise 0.
- Latency:
  - A redirect target appears on fetch_address_o one cycle after redirect_i is sampled.
  - The instruction at that target appears in IF/ID one cycle later, assuming no stall.
- First cycle after reset deasserts: fetch_address_o = RESET_PC and if_id_valid_o = 0. The first valid IF/ID entry appears on the following edge.
- Back-to-back redirects: each redirect overrides the previous one; only the last target is fetched.
- Stall held for N cycles: the IF/ID contents are unchanged for N cycles, and the instruction fetched from the same PC is captured on release.
- Reset asserted mid-stall or mid-redirect: the reset values win on that edge.
- fetch_count saturation: at all-ones, further accepts leave the counter unchanged.

Decomposition:
- Shared package `riscv_pipeline_pkg` holds:
  - RESET_PC, NOP_INSTR, INSTR_BYTES = 4.
  - The IF/ID bundle typedef {pc, pc_plus4, instruction, valid}.
- One natural sub-module, `pc_register`: the DATA_WIDTH register with sync reset to RESET_PC, load enable, and a next-value input.
- Next-PC mux, IF/ID register, misalignment flag and counter stay in the top module.

Test Plan:
- Reset then 4 free-running cycles, ROM modelled as f(addr)=addr ^ 32'hA5A5_0000:
  - fetch_address_o steps 0x400000, 0x400004, 0x400008, 0x40000C.
  - IF/ID lags one cycle with valid=1 from the second edge.
  - fetch_count_o = 3.
- stall_i=1 for 3 cycles at PC=0x400008:
  - PC holds 0x400008.
  - IF/ID holds the 0x400004 entry.
  - fetch_count_o is unchanged.
  - On release, IF/ID gets pc=0x400008, pc_plus4=0x40000C.
- redirect_i=1, target 0x400100:
  - Next cycle fetch_address_o=0x400100, if_id_valid_o=0, if_id_instruction_o=0x00000013.
  - Following cycle IF/ID pc=0x400100, valid=1.
- redirect_i=1 and stall_i=1 in the same cycle with target 0x400040:
  - Redirect wins; PC=0x400040 and IF/ID is flushed.
- Redirect to 0x400042:
  - PC=0x400040, misaligned_o=1 for exactly one cycle, then 0.
- reset asserted during a 2-cycle stall:
  - Next edge PC=0x400000, valid=0, fetch_count_o=0.
  - PC wrap: force PC to 0xFFFFFFFC via redirect, run 1 cycle: fetch_address_o=0 and if_id_pc_plus4_o=0.

Source files
------------

// File: rtl/riscv_pipeline_pkg.sv
// Shared RV32 pipeline definitions: reset/bubble constants and the IF/ID bundle.
package riscv_pipeline_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0040_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instruction;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Control, ROM and IF/ID bundle between the fetch stage and its neighbours.
interface instruction_fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  stall_i;
  logic                  redirect_i;
  logic [DATA_WIDTH-1:0] redirect_target_i;
  logic [DATA_WIDTH-1:0] instruction_i;
  logic [DATA_WIDTH-1:0] fetch_address_o;
  logic [DATA_WIDTH-1:0] if_id_pc_o;
  logic [DATA_WIDTH-1:0] if_id_pc_plus4_o;
  logic [DATA_WIDTH-1:0] if_id_instruction_o;
  logic                  if_id_valid_o;
  logic                  misaligned_o;
  logic [DATA_WIDTH-1:0] fetch_count_o;

  modport master (
    input  stall_i, redirect_i, redirect_target_i, instruction_i,
    output fetch_address_o, if_id_pc_o, if_id_pc_plus4_o, if_id_instruction_o,
           if_id_valid_o, misaligned_o, fetch_count_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_target_i, instruction_i,
    input  fetch_address_o, if_id_pc_o, if_id_pc_plus4_o, if_id_instruction_o,
           if_id_valid_o, misaligned_o, fetch_count_o
  );

endinterface

// File: rtl/pc_register.sv
// Program counter: synchronous reset to the text base, loads next_pc when enabled.
module pc_register #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [DATA_WIDTH-1:0] next_pc,
  output logic [DATA_WIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load_en) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: next-PC selection, ROM addressing and the IF/ID pipeline register.
module instruction_fetch_stage #(
  parameter int                    DATA_WIDTH = riscv_pipeline_pkg::XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = riscv_pipeline_pkg::RESET_PC,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = riscv_pipeline_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_stage_if.master bus
);

  import riscv_pipeline_pkg::*;

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] next_pc;
  logic                  pc_load;
  if_id_t                if_id_q;
  logic                  misaligned_q;
  logic [DATA_WIDTH-1:0] fetch_count_q;

  // A redirect overrides a stall, so the PC loads whenever either redirect or no stall.
  always_comb begin
    pc_plus4 = pc + DATA_WIDTH'(INSTR_BYTES);
    pc_load  = bus.redirect_i | ~bus.stall_i;
    next_pc  = pc_plus4;
    if (bus.redirect_i) begin
      next_pc = {bus.redirect_target_i[DATA_WIDTH-1:2], 2'b00};
    end
  end

  pc_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .reset   (reset),
    .load_en (pc_load),
    .next_pc (next_pc),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_q       <= '{pc: '0, pc_plus4: '0, instruction: NOP_INSTR, valid: 1'b0};
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else if (bus.redirect_i) begin
      if_id_q       <= '{pc: '0, pc_plus4: '0, instruction: NOP_INSTR, valid: 1'b0};
      misaligned_q  <= |bus.redirect_target_i[1:0];
    end else begin
      misaligned_q <= 1'b0;
      if (!bus.stall_i) begin
        if_id_q <= '{pc: pc, pc_plus4: pc_plus4, instruction: bus.instruction_i, valid: 1'b1};
        // The counter sticks at all-ones rather than wrapping.
        if (fetch_count_q != '1) begin
          fetch_count_q <= fetch_count_q + 1'b1;
        end
      end
    end
  end

  assign bus.fetch_address_o     = pc;
  assign bus.if_id_pc_o          = if_id_q.pc;
  assign bus.if_id_pc_plus4_o    = if_id_q.pc_plus4;
  assign bus.if_id_instruction_o = if_id_q.instruction;
  assign bus.if_id_valid_o       = if_id_q.valid;
  assign bus.misaligned_o        = misaligned_q;
  assign bus.fetch_count_o       = fetch_count_q;

endmodule
